// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
// Contents:
//   boot_state_t      - sequencer state encoding
//   TERM_WORD_DEFAULT - ebreak, written after the last program word
//   WORD_BYTES        - byte stride between consecutive program words
package imem_boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TERM  = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4,
        ERROR = 3'd5
    } boot_state_t;

    localparam logic [31:0] TERM_WORD_DEFAULT = 32'h0010_0073;
    localparam int          WORD_BYTES        = 4;

endpackage

// File: rtl/imem_boot_ctrl_budget_timer.sv
// boot_budget_timer: loadable down-counter that measures the core run window.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   load      - load count with load_val (takes priority over en)
//   load_val  - value loaded into the counter
//   en        - decrement by one per cycle while count is non-zero
//   count     - current budget
//   expire    - terminal count: this is the last cycle of the window
module boot_budget_timer #(
    parameter int BUD_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BUD_W-1:0] load_val,
    input  logic             en,
    output logic [BUD_W-1:0] count,
    output logic             expire
);

    // A budget of zero is treated like one so the run window always closes.
    assign expire = (count == BUD_W'(1)) || (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - BUD_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads a program stream into instruction memory while the
// core is held in reset, appends a terminator word, releases the core for a
// budget proportional to program length, then flags halt.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   start, clear        - begin a load (IDLE) / leave HALT or ERROR
//   in_valid/in_ready   - program word handshake; in_data, in_last qualify it
//   mem_we/addr/wdata   - registered instruction-memory write port
//   core_hold           - 1 holds the core in reset
//   running, halted     - run window active / run window expired
//   error               - program exceeded MAX_WORDS
//   word_count          - words accepted in the current load
//
// state | meaning
// IDLE  | core held, waiting for start
// LOAD  | accepting program words, one write per handshake
// TERM  | one cycle: write terminator, load run budget
// RUN   | core released, budget counting down
// HALT  | budget expired, core held, waiting for clear
// ERROR | program overflow, core held, waiting for clear
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          BASE_ADDR    = 4,
    parameter int          MAX_WORDS    = 1024,
    parameter int          CYC_PER_WORD = 1,
    parameter int          RUN_EXTRA    = 2,
    parameter logic [31:0] TERM_WORD    = TERM_WORD_DEFAULT,
    parameter int          CNT_W        = 11,
    parameter int          BUD_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              running,
    output logic              halted,
    output logic              error,
    output logic [CNT_W-1:0]  word_count
);

    boot_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic              hs;
    logic              bud_load;
    logic              bud_en;
    logic              bud_expire;
    logic [BUD_W-1:0]  bud_load_val;
    logic [BUD_W-1:0]  budget;

    assign in_ready = (state == LOAD);
    assign hs       = in_valid && in_ready;

    // word_count is already final while in TERM.
    assign bud_load     = (state == TERM);
    assign bud_en       = (state == RUN);
    assign bud_load_val = BUD_W'(word_count) * BUD_W'(CYC_PER_WORD) + BUD_W'(RUN_EXTRA);

    boot_budget_timer #(
        .BUD_W (BUD_W)
    ) u_budget_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (bud_load),
        .load_val (bud_load_val),
        .en       (bud_en),
        .count    (budget),
        .expire   (bud_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= ADDR_W'(BASE_ADDR);
            word_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= ADDR_W'(BASE_ADDR);
            mem_wdata  <= '0;
            core_hold  <= 1'b1;
            running    <= 1'b0;
            halted     <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_count <= '0;
                        ptr        <= ADDR_W'(BASE_ADDR);
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        // Overflow check wins even if the word carries in_last.
                        if (word_count == CNT_W'(MAX_WORDS)) begin
                            error <= 1'b1;
                            state <= ERROR;
                        end else begin
                            mem_we     <= 1'b1;
                            mem_addr   <= ptr;
                            mem_wdata  <= in_data;
                            ptr        <= ptr + ADDR_W'(WORD_BYTES);
                            word_count <= word_count + CNT_W'(1);
                            if (in_last) begin
                                state <= TERM;
                            end
                        end
                    end
                end
                TERM: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= TERM_WORD;
                    core_hold <= 1'b0;
                    running   <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (bud_expire) begin
                        core_hold <= 1'b1;
                        running   <= 1'b0;
                        halted    <= 1'b1;
                        state     <= HALT;
                    end
                end
                HALT: begin
                    if (clear) begin
                        halted <= 1'b0;
                        state  <= IDLE;
                    end
                end
                ERROR: begin
                    if (clear) begin
                        error <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

    localparam int          ADDR_W   = 32;
    localparam int          BASE     = 4;
    localparam int          MAX_W    = 4;
    localparam int          CYC_PW   = 1;
    localparam int          EXTRA    = 2;
    localparam logic [31:0] TERM_W   = 32'h0010_0073;
    localparam int          CNT_W    = 11;
    localparam int          BUD_W    = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              running;
    logic              halted;
    logic              error;
    logic [CNT_W-1:0]  word_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] wr_q[$];
    logic [31:0] prog_q[$];
    int          hold_low;
    int          rdy_drops;

    imem_boot_ctrl #(
        .ADDR_W       (ADDR_W),
        .BASE_ADDR    (BASE),
        .MAX_WORDS    (MAX_W),
        .CYC_PER_WORD (CYC_PW),
        .RUN_EXTRA    (EXTRA),
        .TERM_WORD    (TERM_W),
        .CNT_W        (CNT_W),
        .BUD_W        (BUD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .running    (running),
        .halted     (halted),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
            if (!core_hold) hold_low++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check_val("clr_halted", halted, 0);
        check_val("clr_error", error, 0);
        check_val("clr_hold", core_hold, 1);
    endtask

    // Start a load and stream prog_q; in_last rides on the final entry.
    // gap_mode: 0 back-to-back, 1 idle cycle before every word, 2 random gaps.
    task automatic send_prog(input int gap_mode);
        int  t;
        wr_q.delete();
        hold_low  = 0;
        rdy_drops = 0;
        pulse_start();
        for (int i = 0; i < prog_q.size(); i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(1, 0) == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (!in_ready) rdy_drops++;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = prog_q[i];
            in_last  = (i == prog_q.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready || t > 20) break;
                rdy_drops++;
                t++;
            end
            check_val("hs_timeout", (t > 20), 0);
            @(posedge clk); #1;
            if (t > 20) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Reference: words land at BASE+4*i; a program within MAX_W words is
    // followed by the terminator and a run of n*CYC_PW+EXTRA cycles; a longer
    // one stops after MAX_W writes with error and no run.
    task automatic finish_check(input string tag);
        logic [63:0] exp_q[$];
        int  n, t, nw;
        bit  ovf;
        n   = prog_q.size();
        ovf = (n > MAX_W);
        nw  = ovf ? MAX_W : n;
        for (int i = 0; i < nw; i++)
            exp_q.push_back({32'(BASE + 4 * i), prog_q[i]});
        if (!ovf) exp_q.push_back({32'(BASE + 4 * n), TERM_W});

        t = 0;
        while (!halted && !error && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_done_timeout"}, (t >= 200), 0);
        repeat (2) @(negedge clk);

        check_val({tag, "_n_writes"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < wr_q.size()) check_val({tag, "_write"}, wr_q[i], exp_q[i]);
        check_val({tag, "_run_cycles"}, hold_low, ovf ? 0 : n * CYC_PW + EXTRA);
        check_val({tag, "_halted"}, halted, !ovf);
        check_val({tag, "_error"}, error, ovf);
        check_val({tag, "_word_count"}, word_count, nw);
        check_val({tag, "_core_hold"}, core_hold, 1);
        check_val({tag, "_running"}, running, 0);
        check_val({tag, "_rdy_drops"}, rdy_drops, 0);
    endtask

    initial begin
        int t;
        rst      = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_addr", mem_addr, BASE);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_core_hold", core_hold, 1);
        check_val("rst_running", running, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_error", error, 0);
        check_val("rst_word_count", word_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_in_ready", in_ready, 0);

        // Directed: three words back-to-back, then the same with gaps.
        prog_q = '{32'h0050_0093, 32'h00a0_0113, 32'h0020_81b3};
        send_prog(0);
        finish_check("t1");
        pulse_clear();
        send_prog(1);
        finish_check("t2");
        pulse_clear();

        // Overflow: five words, in_last only on the fifth.
        prog_q = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
        send_prog(0);
        finish_check("t3");
        pulse_clear();

        // Single word.
        prog_q = '{32'hcafe_0013};
        send_prog(0);
        finish_check("t4");
        pulse_clear();

        // Randomized loads, including overflow lengths.
        for (int it = 0; it < 12; it++) begin
            int n;
            n = $urandom_range(MAX_W + 1, 1);
            prog_q.delete();
            for (int i = 0; i < n; i++) prog_q.push_back($urandom);
            send_prog($urandom_range(2, 0));
            finish_check("rnd");
            pulse_clear();
        end

        // Reset in the middle of RUN, after an ignored start.
        prog_q = '{32'h0050_0093, 32'h00a0_0113, 32'h0020_81b3};
        send_prog(0);
        t = 0;
        while (!running && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("t5_run_timeout", (t >= 50), 0);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        check_val("t5_start_ignored_run", running, 1);
        check_val("t5_start_ignored_cnt", word_count, 3);
        check_val("t5_start_ignored_rdy", in_ready, 0);
        #1 rst = 1'b0;
        #1;
        check_val("t5_async_hold", core_hold, 1);
        check_val("t5_async_running", running, 0);
        check_val("t5_async_we", mem_we, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("t5_idle_rdy", in_ready, 0);
        check_val("t5_idle_hold", core_hold, 1);
        check_val("t5_idle_running", running, 0);
        check_val("t5_idle_halted", halted, 0);

        // From HALT, start with clear returns to IDLE, then a fresh load.
        prog_q = '{32'h0000_0013, 32'h0000_0093};
        send_prog(0);
        finish_check("t6a");
        start = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        check_val("t6_idle_rdy", in_ready, 0);
        check_val("t6_idle_halted", halted, 0);
        @(negedge clk);
        check_val("t6_still_idle", in_ready, 0);
        @(posedge clk); #1;
        prog_q = '{32'hdead_beef, 32'h0123_4567, 32'h89ab_cdef};
        send_prog(2);
        finish_check("t6b");
        pulse_clear();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "global timeout");
    end

endmodule
